// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selector, load-use detector and long-latency scoreboard.
// Drives EX operand muxes and the IF/ID stall / ID/EX bubble control.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned NUM_FWD  = 2,
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned LAT_W    = 4,
  parameter int unsigned SEL_W    = $clog2(NUM_FWD + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
  input  logic [REG_AW-1:0]           ex_rd,
  input  logic                        ex_memread,
  input  logic [NUM_FWD*REG_AW-1:0]   fwd_rd,
  input  logic [NUM_FWD-1:0]          fwd_regwrite,
  input  logic                        issue_valid,
  input  logic [REG_AW-1:0]           issue_rd,
  input  logic [LAT_W-1:0]            issue_lat,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall,
  output logic                        issue_accept,
  output logic                        sb_full,
  output logic [15:0]                 stall_count
);

  localparam int unsigned CNT_W = 16;

  logic [SB_DEPTH-1:0] busy;
  logic [REG_AW-1:0]   sb_rd  [SB_DEPTH];
  logic [LAT_W-1:0]    sb_cnt [SB_DEPTH];
  logic [SB_DEPTH-1:0] alloc_oh;
  logic [LAT_W-1:0]    lat_eff;
  logic                load_use;
  logic                sb_hit;

  // Youngest matching stage wins: only fill a select that is still zero.
  always_comb begin
    fwd_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned k = 0; k < NUM_FWD; k++) begin
        if (fwd_sel[i*SEL_W +: SEL_W] == '0 && fwd_regwrite[k] &&
            fwd_rd[k*REG_AW +: REG_AW] != '0 &&
            fwd_rd[k*REG_AW +: REG_AW] == ex_rs[i*REG_AW +: REG_AW]) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  // Hazard detection against the decode operands that are actually read.
  always_comb begin
    load_use = 1'b0;
    sb_hit   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i]) begin
        if (ex_memread && ex_rd != '0 && ex_rd == id_rs[i*REG_AW +: REG_AW])
          load_use = 1'b1;
        if (issue_valid && issue_rd != '0 && issue_rd == id_rs[i*REG_AW +: REG_AW])
          sb_hit = 1'b1;
        for (int unsigned j = 0; j < SB_DEPTH; j++) begin
          if (busy[j] && sb_rd[j] != '0 && sb_rd[j] == id_rs[i*REG_AW +: REG_AW])
            sb_hit = 1'b1;
        end
      end
    end
  end

  // Lowest-index free entry, from registered busy bits only.
  always_comb begin
    alloc_oh = '0;
    for (int unsigned j = 0; j < SB_DEPTH; j++) begin
      if (!busy[j] && alloc_oh == '0)
        alloc_oh[j] = 1'b1;
    end
  end

  assign sb_full      = &busy;
  assign issue_accept = issue_valid & ~sb_full;
  assign lat_eff      = (issue_lat == '0) ? LAT_W'(1) : issue_lat;
  assign stall        = load_use | sb_hit | (issue_valid & sb_full);

  // Entry at count 1 retires on this edge; its slot is seen free next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      for (int unsigned j = 0; j < SB_DEPTH; j++) begin
        sb_rd[j]  <= '0;
        sb_cnt[j] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < SB_DEPTH; j++) begin
        if (issue_accept && alloc_oh[j]) begin
          busy[j]   <= 1'b1;
          sb_rd[j]  <= issue_rd;
          sb_cnt[j] <= lat_eff;
        end else if (busy[j]) begin
          sb_cnt[j] <= sb_cnt[j] - LAT_W'(1);
          if (sb_cnt[j] == LAT_W'(1))
            busy[j] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (stall && stall_count != {CNT_W{1'b1}})
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit with hand-computed expectations.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [9:0]  ex_rs;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic [9:0]  fwd_rd;
  logic [1:0]  fwd_regwrite;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_lat;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic        issue_accept;
  logic        sb_full;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .fwd_rd(fwd_rd), .fwd_regwrite(fwd_regwrite),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .fwd_sel(fwd_sel), .stall(stall), .issue_accept(issue_accept),
    .sb_full(sb_full), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rs_used = '0; ex_rs = '0; ex_rd = '0; ex_memread = 1'b0;
    fwd_rd = '0; fwd_regwrite = '0; issue_valid = 1'b0; issue_rd = '0; issue_lat = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    chk("rst_sb_full", 32'(sb_full), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_count", 32'(stall_count), 0);
    chk("rst_fwd_sel", 32'(fwd_sel), 0);
    tick();
    rst = 1'b0;

    // Forwarding priority
    ex_rs = {5'd5, 5'd5}; fwd_rd = {5'd5, 5'd5}; fwd_regwrite = 2'b11; #1;
    chk("fwd_youngest", 32'(fwd_sel), 32'b0101);
    fwd_regwrite = 2'b10; #1;
    chk("fwd_older", 32'(fwd_sel), 32'b1010);
    fwd_rd = '0; fwd_regwrite = 2'b11; ex_rs = '0; #1;
    chk("fwd_r0", 32'(fwd_sel), 0);
    ex_rs = {5'd3, 5'd5}; fwd_rd = {5'd3, 5'd5}; #1;
    chk("fwd_mixed", 32'(fwd_sel), 32'b1001);
    ex_rs = {5'd6, 5'd4}; #1;
    chk("fwd_nomatch", 32'(fwd_sel), 0);

    // Load-use
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10; #1;
    chk("lu_stall", 32'(stall), 1);
    tick();
    ex_memread = 1'b0; #1;
    chk("lu_bubble", 32'(stall), 0);
    chk("lu_count", 32'(stall_count), 1);
    ex_memread = 1'b1; id_rs_used = 2'b00; #1;
    chk("lu_unused", 32'(stall), 0);
    ex_rd = 5'd0; id_rs = '0; id_rs_used = 2'b11; #1;
    chk("lu_r0", 32'(stall), 0);

    // Long op rd=9 lat=3
    do_reset();
    id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    issue_valid = 1'b1; issue_rd = 5'd9; issue_lat = 4'd3; #1;
    chk("lo_c0_stall", 32'(stall), 1);
    chk("lo_accept", 32'(issue_accept), 1);
    tick();
    issue_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("lo_c%0d_stall", c), 32'(stall), 1);
      tick();
    end
    chk("lo_c4_release", 32'(stall), 0);
    chk("lo_count", 32'(stall_count), 4);

    // Full scoreboard
    do_reset();
    issue_valid = 1'b1; issue_lat = 4'd10;
    for (int c = 0; c < 4; c++) begin
      issue_rd = 5'(10 + c); #1;
      chk($sformatf("full_acc%0d", c), 32'(issue_accept), 1);
      tick();
    end
    issue_rd = 5'd14; #1;
    chk("full_flag", 32'(sb_full), 1);
    chk("full_noacc", 32'(issue_accept), 0);
    chk("full_stall", 32'(stall), 1);
    for (int c = 5; c <= 11; c++) tick();
    chk("full_freed", 32'(sb_full), 0);
    chk("full_late_acc", 32'(issue_accept), 1);
    chk("full_nostall", 32'(stall), 0);
    chk("full_count", 32'(stall_count), 7);
    tick();
    issue_valid = 1'b0;

    // lat=0 behaves as lat=1; rd=0 never stalls
    do_reset();
    id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
    issue_valid = 1'b1; issue_rd = 5'd3; issue_lat = 4'd0; #1;
    chk("l0_c0", 32'(stall), 1);
    tick();
    issue_valid = 1'b0; #1;
    chk("l0_c1", 32'(stall), 1);
    tick();
    chk("l0_c2", 32'(stall), 0);
    chk("l0_count", 32'(stall_count), 2);
    id_rs = '0; id_rs_used = 2'b11;
    issue_valid = 1'b1; issue_rd = 5'd0; issue_lat = 4'd5; #1;
    chk("rd0_issue", 32'(stall), 0);
    tick();
    issue_valid = 1'b0; #1;
    chk("rd0_busy", 32'(stall), 0);

    // Reset with entries outstanding
    do_reset();
    issue_valid = 1'b1; issue_lat = 4'd10;
    for (int c = 0; c < 3; c++) begin
      issue_rd = 5'(20 + c);
      tick();
    end
    issue_valid = 1'b0; id_rs = {5'd0, 5'd20}; id_rs_used = 2'b01; #1;
    chk("mid_pre_stall", 32'(stall), 1);
    rst = 1'b1; #1;
    chk("mid_sb_full", 32'(sb_full), 0);
    chk("mid_count", 32'(stall_count), 0);
    chk("mid_stall", 32'(stall), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_after", 32'(stall), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
